// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the byte-serialising data-memory arbiter.
//   arb_state_t     : arbiter FSM states
//   BYTES_PER_WORD  : byte cycles per granted word access
//   byte_lane()     : big-endian byte select, k=0 -> bits 31:24
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        TAIL  = 2'd2
    } arb_state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        case (k)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/dmem_word_arbiter_if.sv
// Bundle of requester and byte-memory signals around dmem_word_arbiter.
//   slave  : the arbiter's view (requests and mem_rdata in; grants, results, memory drive out)
//   master : the surrounding environment (requesters plus memory array)
interface dmem_word_arbiter_if #(
    parameter int AW = 6
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          done0, done1;
    logic [31:0]   rdata0, rdata1;
    logic          busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter, purely combinational.
//   req_i        : request vector, bit n = port n
//   last_i       : port granted most recently
//   fixed_prio_i : 1 = port 0 wins every tie
//   gnt_o        : one-hot grant (zero when nobody requests)
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie: the port that did not win last time goes next.
            2'b11:   gnt_o = (fixed_prio_i || last_i) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_word_arbiter.sv
// Serialises 32-bit word accesses from two requesters onto a byte-wide
// synchronous memory, big-endian (base+0 carries bits 31:24).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshakes, word results and byte-memory drive
//
//   state | meaning
//   IDLE  | waiting; arbitrates and latches the winner at the edge
//   ISSUE | four byte cycles k=0..3 on the memory; gnt shown at k=0
//   TAIL  | memory idle; last read byte arrives, done/rdata set at the edge
module dmem_word_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 6,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_word_arbiter_if.slave bus
);

    arb_state_t    state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [23:0]   asm_q, asm_d;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic [1:0]    arb_gnt;
    logic          issuing;

    rr_arb2 u_arb (
        .req_i        ({bus.req1, bus.req0}),
        .last_i       (last_q),
        .fixed_prio_i (FIXED_PRIO),
        .gnt_o        (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            asm_q    <= asm_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        asm_d    = asm_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d = ISSUE;
                    k_d     = 2'd0;
                    owner_d = arb_gnt[1];
                    last_d  = arb_gnt[1];
                    we_d    = arb_gnt[1] ? bus.we1    : bus.we0;
                    addr_d  = arb_gnt[1] ? bus.addr1  : bus.addr0;
                    wdata_d = arb_gnt[1] ? bus.wdata1 : bus.wdata0;
                end
            end
            ISSUE: begin
                // Read data lags the strobe by one cycle, so byte k-1 lands while k issues.
                if (k_q != 2'd0) asm_d = {asm_q[15:0], bus.mem_rdata};
                if (k_q == 2'(BYTES_PER_WORD - 1)) state_d = TAIL;
                else k_d = k_q + 2'd1;
            end
            TAIL: begin
                if (!we_q) begin
                    if (owner_q) rdata1_d = {asm_q, bus.mem_rdata};
                    else         rdata0_d = {asm_q, bus.mem_rdata};
                end
                done0_d = !owner_q;
                done1_d = owner_q;
                k_d     = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign issuing       = (state_q == ISSUE);
    assign bus.gnt0      = issuing && (k_q == 2'd0) && !owner_q;
    assign bus.gnt1      = issuing && (k_q == 2'd0) && owner_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_en    = issuing;
    assign bus.mem_we    = issuing && we_q;
    // Address arithmetic wraps naturally at the top of the array.
    assign bus.mem_addr  = issuing ? (addr_q + AW'(k_q)) : '0;
    assign bus.mem_wdata = issuing ? byte_lane(wdata_q, k_q) : 8'h00;

endmodule

// File: tb/tb_dmem_word_arbiter.sv
module tb_dmem_word_arbiter;
    import dmem_arb_pkg::*;

    typedef struct { int port; int cyc; } gnt_exp_t;
    typedef struct { int cyc; bit we; logic [5:0] addr; logic [7:0] wd; } mem_exp_t;
    typedef struct { int port; int cyc; logic [31:0] rd; } done_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_word_arbiter_if #(.AW(6)) bus ();
    dmem_word_arbiter_if #(.AW(6)) bus_fp ();

    dmem_word_arbiter #(.AW(6), .FIXED_PRIO(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    dmem_word_arbiter #(.AW(6), .FIXED_PRIO(1'b1)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp.slave)
    );

    // Fixed-priority copy sees the same requests; only its grants are checked.
    assign bus_fp.req0      = bus.req0;
    assign bus_fp.req1      = bus.req1;
    assign bus_fp.we0       = bus.we0;
    assign bus_fp.we1       = bus.we1;
    assign bus_fp.addr0     = bus.addr0;
    assign bus_fp.addr1     = bus.addr1;
    assign bus_fp.wdata0    = bus.wdata0;
    assign bus_fp.wdata1    = bus.wdata1;
    assign bus_fp.mem_rdata = 8'h00;

    // Byte memory model: synchronous, read data one cycle after the strobe edge.
    logic [7:0] mem [64];
    logic [7:0] mem_rd_q = 8'h00;
    bit         preloaded = 1'b0;
    assign bus.mem_rdata = mem_rd_q;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[16] <= 8'h12; mem[17] <= 8'h34; mem[18] <= 8'h56; mem[19] <= 8'h78;
            mem[62] <= 8'hA1; mem[63] <= 8'hB2; mem[0]  <= 8'hC3; mem[1]  <= 8'hD4;
            preloaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rd_q <= mem[bus.mem_addr];
        end
    end

    gnt_exp_t  exp_gnt[$];
    gnt_exp_t  exp_fp[$];
    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];
    logic [31:0] rd_model0 = 32'h0;
    logic [31:0] rd_model1 = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_access(input int port, input bit we, input logic [5:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd_exp,
                               input int g, input int nbytes);
        exp_gnt.push_back('{port: port, cyc: g});
        for (int k = 0; k < nbytes; k++)
            exp_mem.push_back('{cyc: g + k, we: we, addr: addr + 6'(k), wd: byte_lane(wd, 2'(k))});
        if (nbytes == BYTES_PER_WORD) begin
            if (!we) begin
                if (port == 0) rd_model0 = rd_exp;
                else           rd_model1 = rd_exp;
            end
            exp_done.push_back('{port: port, cyc: g + 5, rd: (port == 0) ? rd_model0 : rd_model1});
        end
    endtask

    task automatic set_port(input int port, input logic req, input logic we,
                            input logic [5:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end
    endtask

    // Issues one access in the current (IDLE) cycle c and returns in cycle c+6, the done cycle.
    task automatic single(input int port, input logic we, input logic [5:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd_exp);
        int c;
        bit seen;
        c = cyc;
        seen = 1'b0;
        set_port(port, 1'b1, we, addr, wd);
        push_access(port, we, addr, wd, rd_exp, c + 1, 4);
        exp_fp.push_back('{port: port, cyc: c + 1});
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk); #1;
            if ((port == 0) ? bus.gnt0 : bus.gnt1) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL gnt_timeout: port %0d got no grant, required one by cycle %0d", port, c + 1);
        end
        @(posedge clk); #1;
        set_port(port, 1'b0, 1'b0, 6'h00, 32'h0);
        while (cyc < c + 6) begin @(posedge clk); #1; end
    endtask

    gnt_exp_t  mg, mf;
    mem_exp_t  mm;
    done_exp_t md;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt0 || bus.gnt1) begin
                if (exp_gnt.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL gnt_unexpected: gnt={%b,%b} at cycle %0d, required none", bus.gnt1, bus.gnt0, cyc);
                end else begin
                    mg = exp_gnt.pop_front();
                    check("gnt_vec", {30'b0, bus.gnt1, bus.gnt0}, (mg.port == 1) ? 32'd2 : 32'd1);
                    check("gnt_cycle", cyc, mg.cyc);
                end
            end
            if (bus.mem_en) begin
                if (exp_mem.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_unexpected: mem_addr=%h at cycle %0d, required no strobe", bus.mem_addr, cyc);
                end else begin
                    mm = exp_mem.pop_front();
                    check("mem_cycle", cyc, mm.cyc);
                    check("mem_we", {31'b0, bus.mem_we}, {31'b0, mm.we});
                    check("mem_addr", {26'b0, bus.mem_addr}, {26'b0, mm.addr});
                    if (mm.we) check("mem_wdata", {24'b0, bus.mem_wdata}, {24'b0, mm.wd});
                end
            end else begin
                check("idle_mem_drive", {23'b0, bus.mem_we, bus.mem_wdata}, 32'h0);
            end
            if (bus.done0 || bus.done1) begin
                if (exp_done.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected: done={%b,%b} at cycle %0d, required none", bus.done1, bus.done0, cyc);
                end else begin
                    md = exp_done.pop_front();
                    check("done_vec", {30'b0, bus.done1, bus.done0}, (md.port == 1) ? 32'd2 : 32'd1);
                    check("done_cycle", cyc, md.cyc);
                    check("done_rdata", (md.port == 1) ? bus.rdata1 : bus.rdata0, md.rd);
                end
            end
            if (bus_fp.gnt0 || bus_fp.gnt1) begin
                if (exp_fp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fp_gnt_unexpected: gnt={%b,%b} at cycle %0d, required none", bus_fp.gnt1, bus_fp.gnt0, cyc);
                end else begin
                    mf = exp_fp.pop_front();
                    check("fp_gnt_vec", {30'b0, bus_fp.gnt1, bus_fp.gnt0}, (mf.port == 1) ? 32'd2 : 32'd1);
                    check("fp_gnt_cycle", cyc, mf.cyc);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt_done"}, {28'b0, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'h0);
        check({tag, "_busy_en_we"}, {29'b0, bus.busy, bus.mem_en, bus.mem_we}, 32'h0);
        check({tag, "_mem_addr_wdata"}, {18'b0, bus.mem_addr, bus.mem_wdata}, 32'h0);
        check({tag, "_rdata0"}, bus.rdata0, 32'h0);
        check({tag, "_rdata1"}, bus.rdata1, 32'h0);
        check({tag, "_fp_busy"}, {31'b0, bus_fp.busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        set_port(0, 1'b0, 1'b0, 6'h00, 32'h0);
        set_port(1, 1'b0, 1'b0, 6'h00, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        single(0, 1'b0, 6'h10, 32'h0, 32'h12345678);
        single(0, 1'b0, 6'h3E, 32'h0, 32'hA1B2C3D4);
        single(0, 1'b0, 6'h10, 32'h0, 32'h12345678);
        single(1, 1'b1, 6'h20, 32'hDEADBEEF, 32'h0);

        // Continuous tie: round-robin alternates starting with port 0, fixed-priority stays on 0.
        @(posedge clk); #1;
        c = cyc;
        set_port(0, 1'b1, 1'b0, 6'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 6'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_access(0, 1'b0, 6'h10, 32'h0, 32'h12345678, c + 1 + 6 * i, 4);
            else            push_access(1, 1'b0, 6'h20, 32'h0, 32'hDEADBEEF, c + 1 + 6 * i, 4);
            exp_fp.push_back('{port: 0, cyc: c + 1 + 6 * i});
        end
        while (cyc < c + 20) begin @(posedge clk); #1; end
        set_port(0, 1'b0, 1'b0, 6'h00, 32'h0);
        set_port(1, 1'b0, 1'b0, 6'h00, 32'h0);
        while (cyc < c + 24) begin @(posedge clk); #1; end

        // Reset in cycle 3 of a write: two bytes reach memory, no done.
        @(posedge clk); #1;
        c = cyc;
        set_port(0, 1'b1, 1'b1, 6'h08, 32'h11223344);
        push_access(0, 1'b1, 6'h08, 32'h11223344, 32'h0, c + 1, 2);
        exp_fp.push_back('{port: 0, cyc: c + 1});
        while (cyc < c + 3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, 6'h00, 32'h0);
        #1;
        check_all_zero("midreset");
        rd_model0 = 32'h0;
        rd_model1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        single(0, 1'b0, 6'h08, 32'h0, 32'h11220000);

        repeat (4) @(posedge clk);
        #1;
        check("left_gnt", exp_gnt.size(), 32'd0);
        check("left_mem", exp_mem.size(), 32'd0);
        check("left_done", exp_done.size(), 32'd0);
        check("left_fp_gnt", exp_fp.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
